// File: rtl/tick_period_monitor.sv
// tick_period_monitor: measures spacing between upstream ticks, locks on a run of good intervals, flags early/missing ticks with a sticky fault.
module tick_period_monitor #(
  parameter int EXP_PERIOD = 20001,
  parameter int TOL        = 2,
  parameter int LOCK_CNT   = 4,
  parameter int CBITS      = 16,
  parameter int TBITS      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             clr,
  output logic             locked,
  output logic             fault,
  output logic             early,
  output logic             miss,
  output logic [CBITS-1:0] period,
  output logic [TBITS-1:0] tick_cnt
);
  typedef enum logic [1:0] {IDLE, ACQ, LOCK, FAULT} state_t;
  localparam int GBITS = $clog2(LOCK_CNT + 1);
  localparam logic [CBITS-1:0] LO = CBITS'(EXP_PERIOD - TOL);
  localparam logic [CBITS-1:0] HI = CBITS'(EXP_PERIOD + TOL);
  state_t           state_q, state_d;
  logic [CBITS-1:0] ic_q, ic_d, period_q, period_d;
  logic [GBITS-1:0] good_q, good_d;
  logic [TBITS-1:0] tick_cnt_q, tick_cnt_d;
  logic             locked_q, fault_q, early_q, early_d, miss_q, miss_d;
  logic             active, is_good, is_early, is_miss;
  always_comb begin
    active     = state_q == ACQ || state_q == LOCK;
    is_good    = tick && ic_q >= LO && ic_q <= HI;
    is_early   = tick && ic_q < LO;
    is_miss    = !tick && ic_q == HI;
    state_d    = state_q;
    good_d     = good_q;
    tick_cnt_d = tick_cnt_q;
    early_d    = 1'b0;
    miss_d     = 1'b0;
    ic_d       = !active ? '0 : tick ? CBITS'(1) : (&ic_q) ? ic_q : ic_q + CBITS'(1);
    period_d   = active && tick ? ic_q : period_q;
    unique case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = ACQ;
          ic_d    = CBITS'(1);
          good_d  = '0;
        end
      end
      ACQ: begin
        if (is_good) begin
          good_d = good_q + GBITS'(1);
          if (good_q + GBITS'(1) == GBITS'(LOCK_CNT)) begin
            state_d    = LOCK;
            tick_cnt_d = '0;
          end
        end else if (is_early) begin
          early_d = 1'b1;
          good_d  = '0;
        end else if (is_miss) begin
          miss_d  = 1'b1;
          state_d = IDLE;
          good_d  = '0;
          ic_d    = '0;
        end
      end
      LOCK: begin
        if (is_good) begin
          tick_cnt_d = tick_cnt_q + TBITS'(1);
        end else if (is_early || is_miss) begin
          early_d = is_early;
          miss_d  = is_miss;
          state_d = FAULT;
          ic_d    = '0;
        end
      end
      FAULT: begin
        if (clr) begin
          state_d = IDLE;
          good_d  = '0;
        end
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ic_q       <= '0;
      good_q     <= '0;
      period_q   <= '0;
      tick_cnt_q <= '0;
      locked_q   <= 1'b0;
      fault_q    <= 1'b0;
      early_q    <= 1'b0;
      miss_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ic_q       <= ic_d;
      good_q     <= good_d;
      period_q   <= period_d;
      tick_cnt_q <= tick_cnt_d;
      locked_q   <= state_d == LOCK;
      fault_q    <= state_d == FAULT;
      early_q    <= early_d;
      miss_q     <= miss_d;
    end
  end
  assign locked   = locked_q;
  assign fault    = fault_q;
  assign early    = early_q;
  assign miss     = miss_q;
  assign period   = period_q;
  assign tick_cnt = tick_cnt_q;
endmodule

// File: tb/tb_tick_period_monitor.sv
// tb_tick_period_monitor: table of tick/clr/rst steps with expected outputs, checked through a scoreboard queue.
module tb_tick_period_monitor;
  logic       clk = 1'b0, rst = 1'b1, tick = 1'b0, clr = 1'b0;
  logic       locked, fault, early, miss;
  logic [7:0] period;
  logic [2:0] tick_cnt;
  typedef struct packed {
    logic       locked, fault, early, miss;
    logic [7:0] period;
    logic [2:0] tc;
  } out_t;
  typedef struct {
    int   idle;
    logic tick, clr, rst;
    out_t exp;
  } vec_t;
  vec_t vecs[$];
  out_t sb[$];
  out_t got, e;
  int   applied = 0, errs = 0;
  tick_period_monitor #(.EXP_PERIOD(10), .TOL(1), .LOCK_CNT(3), .CBITS(8), .TBITS(3)) dut (
    .clk(clk), .rst(rst), .tick(tick), .clr(clr), .locked(locked), .fault(fault),
    .early(early), .miss(miss), .period(period), .tick_cnt(tick_cnt)
  );
  always #5 clk = ~clk;
  assign got = {locked, fault, early, miss, period, tick_cnt};
  function automatic out_t o(logic l, logic f, logic er, logic m, int p, int c);
    return '{locked: l, fault: f, early: er, miss: m, period: 8'(p), tc: 3'(c)};
  endfunction
  function automatic void add(int idle, logic t, logic c, logic r, out_t x);
    vecs.push_back('{idle: idle, tick: t, clr: c, rst: r, exp: x});
  endfunction
  task automatic step(logic t, logic c, logic r);
    tick = t;
    clr  = c;
    rst  = r;
    @(posedge clk);
    #1;
    tick = 1'b0;
    clr  = 1'b0;
    rst  = 1'b0;
  endtask
  task automatic check(string name);
    e = sb.pop_front();
    applied++;
    if (got !== e) begin
      errs++;
      $display("FAIL %s: got l=%0b f=%0b e=%0b m=%0b per=%0d tc=%0d, want l=%0b f=%0b e=%0b m=%0b per=%0d tc=%0d",
               name, got.locked, got.fault, got.early, got.miss, got.period, got.tc,
               e.locked, e.fault, e.early, e.miss, e.period, e.tc);
    end
  endtask
  initial begin
    add(0, 0, 0, 1, o(0, 0, 0, 0, 0, 0));
    add(3, 1, 0, 0, o(0, 0, 0, 0, 0, 0));
    add(9, 1, 0, 0, o(0, 0, 0, 0, 10, 0));
    add(9, 1, 0, 0, o(0, 0, 0, 0, 10, 0));
    add(9, 1, 0, 0, o(1, 0, 0, 0, 10, 0));
    add(8, 1, 0, 0, o(1, 0, 0, 0, 9, 1));
    add(10, 1, 0, 0, o(1, 0, 0, 0, 11, 2));
    add(7, 1, 0, 0, o(0, 1, 1, 0, 8, 2));
    add(0, 0, 0, 0, o(0, 1, 0, 0, 8, 2));
    add(9, 1, 0, 0, o(0, 1, 0, 0, 8, 2));
    add(2, 1, 1, 0, o(0, 0, 0, 0, 8, 2));
    add(4, 1, 0, 0, o(0, 0, 0, 0, 8, 2));
    add(9, 1, 0, 0, o(0, 0, 0, 0, 10, 2));
    add(9, 1, 0, 0, o(0, 0, 0, 0, 10, 2));
    add(9, 1, 0, 0, o(1, 0, 0, 0, 10, 0));
    add(10, 0, 0, 0, o(0, 1, 0, 1, 10, 0));
    add(0, 0, 0, 0, o(0, 1, 0, 0, 10, 0));
    add(0, 0, 1, 0, o(0, 0, 0, 0, 10, 0));
    add(0, 1, 0, 0, o(0, 0, 0, 0, 10, 0));
    add(9, 1, 0, 0, o(0, 0, 0, 0, 10, 0));
    add(10, 0, 0, 0, o(0, 0, 0, 1, 10, 0));
    add(0, 0, 0, 0, o(0, 0, 0, 0, 10, 0));
    add(1, 1, 0, 0, o(0, 0, 0, 0, 10, 0));
    add(9, 1, 0, 0, o(0, 0, 0, 0, 10, 0));
    add(4, 1, 0, 0, o(0, 0, 1, 0, 5, 0));
    add(9, 1, 0, 0, o(0, 0, 0, 0, 10, 0));
    add(9, 1, 0, 0, o(0, 0, 0, 0, 10, 0));
    add(9, 1, 0, 0, o(1, 0, 0, 0, 10, 0));
    for (int i = 0; i < 10; i++) add(9, 1, 0, 0, o(1, 0, 0, 0, 10, (i + 1) % 8));
    add(3, 1, 0, 1, o(0, 0, 0, 0, 0, 0));
    add(0, 1, 0, 0, o(0, 0, 0, 0, 0, 0));
    add(9, 1, 0, 0, o(0, 0, 0, 0, 10, 0));
    repeat (2) @(posedge clk);
    #1;
    foreach (vecs[i]) begin
      for (int k = 0; k < vecs[i].idle; k++) begin
        step(0, 0, 0);
        if (early || miss) begin
          errs++;
          $display("FAIL idle_pulse vec %0d: early=%0b miss=%0b, want 0 0", i, early, miss);
        end
      end
      sb.push_back(vecs[i].exp);
      step(vecs[i].tick, vecs[i].clr, vecs[i].rst);
      check($sformatf("vec%0d", i));
    end
    for (int k = 0; k < 3; k++) begin
      sb.push_back(o(0, 0, 0, 0, 0, 0));
      step(1, 1, 1);
      check($sformatf("rst_hold%0d", k));
    end
    $display("== %0d vectors applied, %0d miscompares ==", applied, errs);
    $finish;
  end
endmodule
